// File: rtl/xcvu440_areset_pkg.sv
// Shared definitions for the board-level areset controller.
// Provides the 2-bit state encoding (RST / WAIT_LOCK / STABLE / RUN) and the
// helper that sizes the sequencing counter so no state can ever wrap it.
package xcvu440_areset_pkg;

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } ar_state_e;

  // Width able to hold the largest terminal count of any state.
  function automatic int ar_ctr_width(input int rst_cycles, input int stable_cycles,
                                      input int lock_timeout);
    int m;
    m = rst_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (lock_timeout > m) m = lock_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/areset_ctrl_debounce.sv
// Button conditioning for the areset controller: synchroniser, debounce
// counter and press-edge detect.
// Ports:
//   clock      in  free-running board clock
//   reset      in  synchronous active-high; forces the "released" level
//   button_n   in  asynchronous active-low button
//   btn_press  out single-cycle pulse when a debounced press is accepted
// A press is accepted on the 2^DEBOUNCE_BITS-th consecutive low sample; the
// detector then waits for an equally long high run before it can fire again.
module areset_ctrl_debounce #(
  parameter int SYNC_STAGES   = 3,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic btn_press
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = DEBOUNCE_BITS'(1);

  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     level_q, level_d;  // debounced level, 1 = released
  logic                     synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], button_n};

  // The counter only runs while the synced input disagrees with the accepted
  // level, so any bounce back to the old level restarts the qualification.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    btn_press = 1'b0;
    if (synced == level_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      level_d   = synced;
      cnt_d     = '0;
      btn_press = ~synced;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/xcvu440_areset_ctrl.sv
// Upstream stage of the board reset tree. Supervises MMCM lock and the user
// button, pulses mmcm_rst and releases areset only after a stable-lock window.
// Runs on the free-running board oscillator.
// Ports:
//   clock        in  free-running board clock
//   reset        in  synchronous active-high; restarts the sequence
//   button_n     in  async active-low user reset button
//   mmcm_locked  in  async lock indications, one per MMCM
//   mmcm_rst     out reset to all MMCMs (high while in RST)
//   areset       out to downstream reset-hold stage, high = in reset
//   state        out 0 RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   lock_lost    out sticky: lock dropped while in RUN
//   retry_count  out saturating count of lock timeouts
// Build option: define AR_LOCK_TIMEOUT_EN to retry the MMCM reset after
// LOCK_TIMEOUT cycles in WAIT_LOCK; otherwise WAIT_LOCK waits forever and
// retry_count stays 0.
module xcvu440_areset_ctrl
  import xcvu440_areset_pkg::*;
#(
  parameter int NUM_MMCM        = 2,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_BITS   = 16,
  parameter int MMCM_RST_CYCLES = 64,
  parameter int STABLE_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT    = 1048576
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                button_n,
  input  logic [NUM_MMCM-1:0] mmcm_locked,
  output logic                mmcm_rst,
  output logic                areset,
  output logic [1:0]          state,
  output logic                lock_lost,
  output logic [7:0]          retry_count
);

  localparam int CW = ar_ctr_width(MMCM_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] RST_LAST   = CW'(MMCM_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
`ifdef AR_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST   = CW'(LOCK_TIMEOUT - 1);
`endif

  logic                btn_press;
  logic [NUM_MMCM-1:0] locked_sync;
  logic                all_locked;

  areset_ctrl_debounce #(
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) u_btn (
    .clock     (clock),
    .reset     (reset),
    .button_n  (button_n),
    .btn_press (btn_press)
  );

  // Lock synchronisers reset to "not locked" so nothing is trusted until the
  // chain has refilled with real samples.
  for (genvar gi = 0; gi < NUM_MMCM; gi++) begin : g_lock_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    assign sync_d = {sync_q[SYNC_STAGES-2:0], mmcm_locked[gi]};
    always_ff @(posedge clock) begin
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
    end
    assign locked_sync[gi] = sync_q[SYNC_STAGES-1];
  end

  assign all_locked = &locked_sync;

  ar_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_lost_q, lock_lost_d;
  logic [7:0]    retry_q, retry_d;
  logic          mmcm_rst_q, areset_q;

  // Priority: button press beats everything, then lock loss, then the
  // per-state counter expiry. Every state exit clears the counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;
    retry_d     = retry_q;
    if (btn_press) begin
      state_d = ST_RST;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (all_locked) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end
`ifdef AR_LOCK_TIMEOUT_EN
          else if (cnt_q == TMO_LAST) begin
            state_d = ST_RST;
            cnt_d   = '0;
            if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`endif
        end
        ST_STABLE: begin
          // Any drop restarts the full window from WAIT_LOCK.
          if (!all_locked) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!all_locked) begin
            state_d     = ST_RST;
            cnt_d       = '0;
            lock_lost_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
      retry_q     <= '0;
      mmcm_rst_q  <= 1'b1;
      areset_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
      mmcm_rst_q  <= (state_d == ST_RST);
      areset_q    <= (state_d != ST_RUN);
    end
  end

  assign mmcm_rst    = mmcm_rst_q;
  assign areset      = areset_q;
  assign state       = state_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_xcvu440_areset_ctrl.sv
// Bench for xcvu440_areset_ctrl. Every driven cycle is fed to a behavioural
// model (input delay lines, run-length button qualifier, time-stamped state
// entries); the predicted outputs are queued and a negedge monitor compares
// them with the DUT. Directed phases add constant-timing spot checks.
module tb_xcvu440_areset_ctrl;

  localparam int NM  = 2;
  localparam int SS  = 2;
  localparam int DB  = 3;
  localparam int MRC = 4;
  localparam int SC  = 8;
  localparam int LT  = 32;
  localparam int DEB_N = 1 << DB;
`ifdef AR_LOCK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          button_n;
  logic [NM-1:0] mmcm_locked;
  logic          mmcm_rst;
  logic          areset;
  logic [1:0]    state;
  logic          lock_lost;
  logic [7:0]    retry_count;

  xcvu440_areset_ctrl #(
    .NUM_MMCM(NM), .SYNC_STAGES(SS), .DEBOUNCE_BITS(DB),
    .MMCM_RST_CYCLES(MRC), .STABLE_CYCLES(SC), .LOCK_TIMEOUT(LT)
  ) dut (
    .clock(clock), .reset(reset), .button_n(button_n), .mmcm_locked(mmcm_locked),
    .mmcm_rst(mmcm_rst), .areset(areset), .state(state),
    .lock_lost(lock_lost), .retry_count(retry_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] st;
    logic       mr;
    logic       ar;
    logic       ll;
    logic [7:0] rc;
  } exp_t;

  exp_t          exp_q[$];
  bit            btn_hist[$];
  bit [NM-1:0]   lock_hist[$];
  int            m_n = 0;
  int            m_state, m_enter, m_low_run, m_high_run, m_retry;
  bit            m_armed, m_lost;

  task automatic m_go(input int s);
    m_state = s;
    m_enter = m_n;
  endtask

  task automatic model_step(input bit r, input bit b, input bit [NM-1:0] l);
    bit          seen_b;
    bit [NM-1:0] seen_l;
    bit          all, press;
    int          el;
    exp_t        e;
    m_n++;
    if (r) begin
      btn_hist = {};
      lock_hist = {};
      for (int i = 0; i < SS; i++) begin
        btn_hist.push_back(1'b1);
        lock_hist.push_back('0);
      end
      m_low_run = 0; m_high_run = 0; m_armed = 1'b1;
      m_lost = 1'b0; m_retry = 0;
      m_go(0);
    end else begin
      // what the control logic sees is the input from SS edges ago
      seen_b = btn_hist[SS-1];
      seen_l = lock_hist[SS-1];
      btn_hist.push_front(b);  void'(btn_hist.pop_back());
      lock_hist.push_front(l); void'(lock_hist.pop_back());
      all = &seen_l;
      if (seen_b) begin m_high_run++; m_low_run = 0; end
      else        begin m_low_run++;  m_high_run = 0; end
      press = 1'b0;
      if (m_armed && m_low_run == DEB_N) begin press = 1'b1; m_armed = 1'b0; end
      if (!m_armed && m_high_run == DEB_N) m_armed = 1'b1;
      el = m_n - m_enter;
      if (press) m_go(0);
      else begin
        case (m_state)
          0: if (el == MRC) m_go(1);
          1: begin
            if (all) m_go(2);
            else if (TMO_EN && el == LT) begin
              m_go(0);
              if (m_retry < 255) m_retry++;
            end
          end
          2: begin
            if (!all) m_go(1);
            else if (el == SC) m_go(3);
          end
          default: if (!all) begin m_go(0); m_lost = 1'b1; end
        endcase
      end
    end
    e.st = 2'(m_state);
    e.mr = (m_state == 0);
    e.ar = (m_state != 3);
    e.ll = m_lost;
    e.rc = 8'(m_retry);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mon_state", int'(state), int'(e.st));
      chk("mon_mmcm_rst", int'(mmcm_rst), int'(e.mr));
      chk("mon_areset", int'(areset), int'(e.ar));
      chk("mon_lock_lost", int'(lock_lost), int'(e.ll));
      chk("mon_retry_count", int'(retry_count), int'(e.rc));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit b, input bit [NM-1:0] l);
    reset = r;
    button_n = b;
    mmcm_locked = l;
    model_step(r, b, l);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int first, first2, entries;
    bit prev_mr, any;
    bit [NM-1:0] lk;
    bit bt;
    reset = 1'b1; button_n = 1'b1; mmcm_locked = '0;

    // bring-up: locks high from cycle 0
    repeat (3) step(1'b1, 1'b1, 2'b11);
    chk("reset_state", int'(state), 0);
    chk("reset_areset", int'(areset), 1);
    chk("reset_mmcm_rst", int'(mmcm_rst), 1);
    first = -1; first2 = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1, 2'b11);
      if (first2 < 0 && !mmcm_rst) first2 = k;
      if (first < 0 && !areset) first = k;
    end
    chk("bringup_mmcm_rst_fall_edge", first2, MRC);
    chk("bringup_areset_fall_edge", first, MRC + 1 + SC);
    chk("bringup_state_run", int'(state), 3);
    $display("phase bringup: mmcm_rst fell at %0d, areset fell at %0d", first2, first);

    // stable-window restart: lock[0] low for one cycle at STABLE count 5
    step(1'b1, 1'b1, 2'b11);
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1, (k == 8) ? 2'b10 : 2'b11);
      if (first < 0 && !areset) first = k;
    end
    chk("restart_areset_fall_edge", first, 10 + 1 + SC);
    $display("phase stable_restart: areset fell at %0d", first);

    // lock loss in RUN
    first = -1; first2 = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b1, (k <= 4) ? 2'b01 : 2'b11);
      if (first < 0 && areset) first = k;
      if (first2 < 0 && mmcm_rst) first2 = k;
    end
    chk("lockloss_areset_rise_edge", first, SS + 1);
    chk("lockloss_mmcm_rst_rise_edge", first2, SS + 1);
    chk("lockloss_sticky", int'(lock_lost), 1);
    chk("lockloss_relocked_run", int'(state), 3);
    $display("phase lock_loss: areset rose at %0d", first);

    // button: 7 low cycles must be ignored
    any = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      step(1'b0, (k <= DEB_N - 1) ? 1'b0 : 1'b1, 2'b11);
      if (areset) any = 1'b1;
    end
    chk("btn_short_no_entry", int'(any), 0);
    // 8 low cycles: one entry
    first = -1;
    for (int k = 1; k <= 33; k++) begin
      step(1'b0, (k <= DEB_N) ? 1'b0 : 1'b1, 2'b11);
      if (first < 0 && areset) first = k;
    end
    chk("btn_press_entry_edge", first, SS + DEB_N);
    // long hold then release and re-press: exactly one entry each
    for (int pass = 0; pass < 2; pass++) begin
      entries = 0; prev_mr = mmcm_rst;
      for (int k = 1; k <= 65; k++) begin
        step(1'b0, (k <= ((pass == 0) ? 40 : 10)) ? 1'b0 : 1'b1, 2'b11);
        if (mmcm_rst && !prev_mr) entries++;
        prev_mr = mmcm_rst;
      end
      chk(pass == 0 ? "btn_hold_single_entry" : "btn_repress_entry", entries, 1);
    end
    $display("phase button: press entry at %0d", first);

    // randomized stress
    lk = 2'b11; bt = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NM; i++) begin
        if (lk[i] ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 5) == 0))
          lk[i] = ~lk[i];
      end
      if (bt ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 11) == 0)) bt = ~bt;
      step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, bt, lk);
    end
    $display("phase random: 3000 cycles");

    // reset mid-STABLE
    step(1'b1, 1'b1, 2'b11);
    repeat (7) step(1'b0, 1'b1, 2'b11);
    chk("midstable_in_stable", int'(state), 2);
    step(1'b1, 1'b1, 2'b11);
    chk("midstable_reset_state", int'(state), 0);
    chk("midstable_reset_areset", int'(areset), 1);
    chk("midstable_reset_mmcm_rst", int'(mmcm_rst), 1);
    chk("midstable_reset_retry", int'(retry_count), 0);
    $display("phase reset_mid_stable: state=%0d", state);

    // locks held low
    if (TMO_EN) begin
      repeat (36 * 258) step(1'b0, 1'b1, 2'b00);
      chk("timeout_retry_saturated", int'(retry_count), 255);
    end else begin
      repeat (300) step(1'b0, 1'b1, 2'b00);
      chk("nolock_wait_forever", int'(state), 1);
      chk("nolock_retry_zero", int'(retry_count), 0);
    end
    $display("phase locks_low: state=%0d retry_count=%0d", state, retry_count);

    @(negedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
